// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, funct3 encodings and FSM state type for the MEM stage
package mem_pkg;
    localparam int XLEN = 64;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: shifts the loaded doubleword down to the access offset and sign/zero-extends it
module load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [XLEN-1:0] s;
    always_comb begin
        s = rdata >> {off, 3'b000};
        data = funct3 == F3_B  ? {{56{s[7]}}, s[7:0]} :
               funct3 == F3_H  ? {{48{s[15]}}, s[15:0]} :
               funct3 == F3_W  ? {{32{s[31]}}, s[31:0]} :
               funct3 == F3_BU ? {56'b0, s[7:0]} :
               funct3 == F3_HU ? {48'b0, s[15:0]} :
               funct3 == F3_WU ? {32'b0, s[31:0]} : s;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: issues loads/stores over req/ack, stalls upstream while waiting, registers MEM/WB
module mem_access_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            MemtoReg,
    input  logic            RegWrite,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_MemtoReg,
    output logic            wb_RegWrite,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_mem_data,
    output logic [4:0]      wb_rd,
    output logic            mem_fault
);
    import mem_pkg::*;
    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0]      wstrb_q, wstrb_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic            we_q, we_d, mtr_q, mtr_d, rw_q, rw_d;
    logic            wb_valid_q, wb_valid_d, wb_mtr_q, wb_mtr_d, wb_rw_q, wb_rw_d;
    logic [XLEN-1:0] wb_alu_q, wb_alu_d, wb_mem_q, wb_mem_d;
    logic            fault_q, fault_d;
    logic            mem_op, misaligned, illegal, fault;
    logic [2:0]      off;
    logic [XLEN-1:0] load_val;
    load_align u_load_align (
        .rdata  (dmem_rdata),
        .off    (addr_q[2:0]),
        .funct3 (f3_q),
        .data   (load_val)
    );
    always_comb begin
        off = alu_result[2:0];
        mem_op = MemRead | MemWrite;
        misaligned = funct3[1:0] == 2'd1 ? off[0] :
                     funct3[1:0] == 2'd2 ? |off[1:0] :
                     funct3[1:0] == 2'd3 ? |off : 1'b0;
        illegal = (MemRead & MemWrite) | (MemRead & funct3 == 3'b111) | (MemWrite & funct3[2]);
        fault = mem_op & (misaligned | illegal);
        state_d = state_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        f3_d = f3_q;
        rd_d = rd_q;
        we_d = we_q;
        mtr_d = mtr_q;
        rw_d = rw_q;
        wb_valid_d = 1'b0;
        wb_mtr_d = wb_mtr_q;
        wb_rw_d = wb_rw_q;
        wb_alu_d = wb_alu_q;
        wb_mem_d = wb_mem_q;
        wb_rd_d = wb_rd_q;
        fault_d = 1'b0;
        if (state_q == ST_IDLE && in_valid) begin
            if (!mem_op || fault) begin
                wb_valid_d = 1'b1;
                wb_mtr_d = MemtoReg;
                wb_rw_d = RegWrite & ~fault;
                wb_alu_d = alu_result;
                wb_mem_d = '0;
                wb_rd_d = rd;
                fault_d = fault;
            end else begin
                state_d = ST_WAIT;
                addr_d = alu_result;
                f3_d = funct3;
                we_d = MemWrite;
                mtr_d = MemtoReg;
                rw_d = RegWrite;
                rd_d = rd;
                wdata_d = store_data << {off, 3'b000};
                wstrb_d = funct3[1:0] == 2'd0 ? 8'h01 << off :
                          funct3[1:0] == 2'd1 ? 8'h03 << off :
                          funct3[1:0] == 2'd2 ? 8'h0F << off : 8'hFF;
            end
        end else if (state_q == ST_WAIT && dmem_ack) begin
            state_d = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_mtr_d = mtr_q;
            wb_rw_d = rw_q;
            wb_alu_d = addr_q;
            wb_mem_d = we_q ? '0 : load_val;
            wb_rd_d = rd_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            f3_q <= '0;
            rd_q <= '0;
            we_q <= 1'b0;
            mtr_q <= 1'b0;
            rw_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_mtr_q <= 1'b0;
            wb_rw_q <= 1'b0;
            wb_alu_q <= '0;
            wb_mem_q <= '0;
            wb_rd_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            f3_q <= f3_d;
            rd_q <= rd_d;
            we_q <= we_d;
            mtr_q <= mtr_d;
            rw_q <= rw_d;
            wb_valid_q <= wb_valid_d;
            wb_mtr_q <= wb_mtr_d;
            wb_rw_q <= wb_rw_d;
            wb_alu_q <= wb_alu_d;
            wb_mem_q <= wb_mem_d;
            wb_rd_q <= wb_rd_d;
            fault_q <= fault_d;
        end
    end
    assign stall = state_q == ST_WAIT;
    assign dmem_req = state_q == ST_WAIT;
    assign dmem_we = we_q;
    assign dmem_addr = {addr_q[XLEN-1:3], 3'b000};
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign wb_valid = wb_valid_q;
    assign wb_MemtoReg = wb_mtr_q;
    assign wb_RegWrite = wb_rw_q;
    assign wb_alu_result = wb_alu_q;
    assign wb_mem_data = wb_mem_q;
    assign wb_rd = wb_rd_q;
    assign mem_fault = fault_q;
endmodule
